zlib_pack: RTL
==============

# zlib_pack

Packs raw deflate output into a zlib stream (RFC 1950) for the PNG IDAT path. It prepends the 2-byte zlib header, re-aligns 32-bit deflate words around it, and appends the 4-byte big-endian Adler-32 trailer. The data source is the deflate stage; the checksum source is the `adler32` stage, which runs on the uncompressed bytes. The output feeds the IDAT chunk builder.

## Interface
- `CMF`, 8'h78: zlib CMF byte (deflate, 32K window).
- `FLG`, 8'h01: zlib FLG byte; must satisfy (CMF*256+FLG) % 31 == 0.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start_i`  in  1  1-cycle pulse that begins a stream; honoured in IDLE only.
- `val_i`  in  1  deflate word valid; legal only while `rdy_o`=1.
- `dat_i`  in  32  deflate bytes, first byte in [31:24].
- `num_i`  in  3  valid bytes in `dat_i`, range 1..4, left-justified; must be 4 unless `lst_i`.
- `lst_i`  in  1  last deflate word; qualified by `val_i`.
- `adler_val_i`  in  1  checksum valid pulse.
- `adler_i`  in  32  Adler-32 value, {s2,s1}; sampled when `adler_val_i`=1.
- `rdy_o`  out  1  accepts deflate words.
- `val_o`  out  1  output word valid.
- `dat_o`  out  32  zlib bytes, first byte in [31:24]; unused low bytes are 0.
- `num_o`  out  3  valid bytes in `dat_o` (1..4).
- `lst_o`  out  1  final zlib word.
- `done_o`  out  1  1-cycle pulse, one cycle after the `lst_o` word.

## Operation
- States: IDLE, DATA, WAIT_ADL, TAIL.
- **IDLE**
  - `rdy_o`=0.
  - On `start_i`: residue register <= {CMF,FLG}; clear the adler-latched flag; go to DATA.
- **DATA**
  - `rdy_o`=1. The residue always holds exactly 2 bytes.
  - `val_i` & !`lst_i`: emit {res[15:0], dat_i[31:16]} with `num_o`=4; res <= dat_i[15:0].
  - `val_i` & `lst_i`: no output this cycle. Tail buffer <= res followed by the top `num_i` bytes of `dat_i`; tail count <= 2+`num_i` (3..6). Go to WAIT_ADL.
- **Adler capture**
  - `adler_val_i` in any non-IDLE state latches `adler_i` and sets the flag.
  - If it arrives more than once, the last one wins.
- **WAIT_ADL**
  - `rdy_o`=0.
  - When the flag is set, or `adler_val_i` arrives this cycle: append the 4 adler bytes (s2 high byte first) to the tail buffer; count becomes 7..10. Go to TAIL.
- **TAIL**
  - `rdy_o`=0.
  - Emit one word per cycle from the front of the buffer and decrement the count by 4 per word.
  - The final word has `num_o` = remaining count (1..4) and `lst_o`=1; its unused bytes are 0.
  - Then go to IDLE and assert `done_o` the next cycle.
- **Word counts by total tail bytes**
  - 7 → 4, 3
  - 8 → 4, 4
  - 9 → 4, 4, 1
  - 10 → 4, 4, 2
- **Illegal or ignored input**
  - `start_i` outside IDLE is ignored.
  - `val_i` with `rdy_o`=0 is ignored.
  - A non-last word with `num_i`≠4 is a protocol error; behaviour is undefined and an assertion flags it in simulation.
- **Empty deflate stream:** not supported; at least one `val_i` with `lst_i` is required.

## Timing
- **Reset values:** state=IDLE; `rdy_o`=0, `val_o`=0, `dat_o`=0, `num_o`=0, `lst_o`=0, `done_o`=0; adler flag=0; residue and tail buffer=0.
- `rdy_o` is registered: it rises the cycle after `start_i` is sampled.
- **Output latency:** every output is registered; a DATA output word appears 1 cycle after its `val_i`.
- **Throughput:** 1 word/cycle in DATA, with no stalls.
- **From the `lst_i` cycle:**
  - WAIT_ADL on cycle+1.
  - If the adler value is already latched, the first TAIL word is on cycle+2.
  - Otherwise the first TAIL word is 1 cycle after the `adler_val_i` cycle.
- **Simultaneous events:** `adler_val_i` in the same cycle as `lst_i` is latched and handled as already latched.
- **Reset mid-stream:** `rst` wins in any state. The next cycle is IDLE with all outputs 0 and no `done_o`.
- **Back-to-back streams:** a `start_i` in the `done_o` cycle is accepted.

## Test plan
- **Two words, adler early.** start; 0x11223344; 0x55667788 (`num_i`=4, lst); `adler_i`=0xAABBCCDD given during DATA.
  - Required output: 0x78011122/4, 0x33445566/4, 0x7788AABB/4, 0xCCDD0000/2 with `lst_o`.
  - `done_o` one cycle after the last word.
- **Single short word.** start; 0xAB000000 `num_i`=1 lst; adler 0x12345678.
  - Required output: 0x7801AB12/4, then 0x34567800/3 with `lst_o`.
- **Late adler.** As the first test, with `adler_val_i` 5 cycles after `lst_i`.
  - Held in WAIT_ADL, `val_o`=0 and `rdy_o`=0 throughout.
  - First TAIL word 1 cycle after `adler_val_i`; output bytes identical to the first test.
- **Two bytes on last.** start; 0xDEADBEEF; 0xCAFE0000 `num_i`=2 lst; adler 0x01020304.
  - Required output: 0x7801DEAD/4, 0xBEEFCAFE/4, 0x01020304/4 with `lst_o`.
- **Reset mid-stream.** Assert `rst` in TAIL after the first tail word.
  - Next cycle: all outputs 0, `rdy_o`=0, no `done_o`.
  - A fresh start then reproduces the first test exactly.
- **Ignored control.** `start_i` during DATA and `val_i` during WAIT_ADL.
  - Both ignored; the output stream is unchanged.

Source files
------------

// File: rtl/zlib_pack.sv
// zlib_pack: wraps raw deflate words into a zlib stream for the PNG IDAT path.
// Prepends the CMF/FLG header, realigns the body around it and appends Adler-32.
module zlib_pack #(
  parameter logic [7:0] CMF = 8'h78,
  parameter logic [7:0] FLG = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        val_i,
  input  logic [31:0] dat_i,
  input  logic [2:0]  num_i,
  input  logic        lst_i,
  input  logic        adler_val_i,
  input  logic [31:0] adler_i,
  output logic        rdy_o,
  output logic        val_o,
  output logic [31:0] dat_o,
  output logic [2:0]  num_o,
  output logic        lst_o,
  output logic        done_o
);

  typedef enum logic [1:0] {IDLE, DATA, WAIT_ADL, TAIL} state_t;

  state_t      state, state_n;
  logic [15:0] res, res_n;
  logic [79:0] tbuf, tbuf_n;
  logic [3:0]  tcnt, tcnt_n;
  logic [31:0] adl, adl_n;
  logic        adl_flag, adl_flag_n;
  logic        rdy_n, val_n, lst_n, done_n;
  logic [31:0] dat_n;
  logic [2:0]  num_n;
  logic [31:0] adl_cur;
  logic [79:0] tail_full;

  // Keep the top n bytes of a left-justified word, zeroing the rest.
  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd1:    return {d[31:24], 24'h0};
      3'd2:    return {d[31:16], 16'h0};
      3'd3:    return {d[31:8], 8'h0};
      default: return d;
    endcase
  endfunction

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n    = state;
    res_n      = res;
    tbuf_n     = tbuf;
    tcnt_n     = tcnt;
    adl_n      = adl;
    adl_flag_n = adl_flag;
    rdy_n      = 1'b0;
    val_n      = 1'b0;
    dat_n      = '0;
    num_n      = '0;
    lst_n      = 1'b0;
    done_n     = lst_o;
    adl_cur    = adler_val_i ? adler_i : adl;
    tail_full  = tbuf | ({adl_cur, 48'h0} >> {tcnt, 3'b000});

    if (state != IDLE && adler_val_i) begin
      adl_n      = adler_i;
      adl_flag_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (start_i) begin
          res_n      = {CMF, FLG};
          adl_flag_n = 1'b0;
          rdy_n      = 1'b1;
          state_n    = DATA;
        end
      end
      DATA: begin
        rdy_n = 1'b1;
        if (val_i && rdy_o) begin
          if (!lst_i) begin
            val_n = 1'b1;
            dat_n = {res, dat_i[31:16]};
            num_n = 3'd4;
            res_n = dat_i[15:0];
          end else begin
            tbuf_n  = {res, keep_bytes(dat_i, num_i), 32'h0};
            tcnt_n  = 4'd2 + {1'b0, num_i};
            rdy_n   = 1'b0;
            state_n = WAIT_ADL;
          end
        end
      end
      WAIT_ADL: begin
        // The first tail word always carries 4 bytes, so it leaves with the merge.
        if (adl_flag || adler_val_i) begin
          val_n   = 1'b1;
          dat_n   = tail_full[79:48];
          num_n   = 3'd4;
          tbuf_n  = {tail_full[47:0], 32'h0};
          state_n = TAIL;
        end
      end
      TAIL: begin
        val_n = 1'b1;
        dat_n = tbuf[79:48];
        if (tcnt <= 4'd4) begin
          num_n   = tcnt[2:0];
          lst_n   = 1'b1;
          state_n = IDLE;
        end else begin
          num_n  = 3'd4;
          tcnt_n = tcnt - 4'd4;
          tbuf_n = {tbuf[47:0], 32'h0};
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      res      <= '0;
      tbuf     <= '0;
      tcnt     <= '0;
      adl      <= '0;
      adl_flag <= 1'b0;
      rdy_o    <= 1'b0;
      val_o    <= 1'b0;
      dat_o    <= '0;
      num_o    <= '0;
      lst_o    <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_n;
      res      <= res_n;
      tbuf     <= tbuf_n;
      tcnt     <= tcnt_n;
      adl      <= adl_n;
      adl_flag <= adl_flag_n;
      rdy_o    <= rdy_n;
      val_o    <= val_n;
      dat_o    <= dat_n;
      num_o    <= num_n;
      lst_o    <= lst_n;
      done_o   <= done_n;
    end
  end

  property p_full_word;
    @(posedge clk) disable iff (rst) (rdy_o && val_i && !lst_i) |-> (num_i == 3'd4);
  endproperty
  a_full_word: assert property (p_full_word);

endmodule
